quad_paddle_ctrl: RTL and testbench

//  Upstream input stage for the Pong game. It synchronises and glitch-filters the rotary encoder pins ROT_A/ROT_B.
//  It decodes x4 quadrature steps and maintains a saturating paddle position.
//  The Pong core consumes pos directly as the manual bouncer X origin, replacing its inline quad decoder.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pin_sync_filter.sv | 33 +++
 rtl/quad_paddle_ctrl.sv | 78 +++++++
 tb/tb_quad_paddle_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared paddle limits and quadrature event encoding for the Pong input path
package pong_pkg;
  localparam int PADDLE_POS_W = 10;
  localparam int PADDLE_MIN   = 0;
  localparam int PADDLE_MAX   = 520;
  localparam int PADDLE_INIT  = 260;
  typedef enum logic [1:0] {
    QUAD_NONE = 2'd0,
    QUAD_CW   = 2'd1,
    QUAD_CCW  = 2'd2,
    QUAD_ERR  = 2'd3
  } quad_ev_t;
  // Gray {a,b} to phase index: 00->0, 10->1, 11->2, 01->3
  function automatic logic [1:0] quad_idx(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction
  function automatic quad_ev_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = quad_idx(cur) - quad_idx(prev);
    return d == 2'd1 ? QUAD_CW : d == 2'd3 ? QUAD_CCW : d == 2'd2 ? QUAD_ERR : QUAD_NONE;
  endfunction
endpackage

// File: rtl/pin_sync_filter.sv
// pin_sync_filter: metastability synchroniser followed by a stable-count glitch filter
module pin_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic filt_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, diff, done;
  always_comb begin
    diff   = sync_q[SYNC_STAGES-1] != filt_q;
    done   = diff && (cnt_q == CW'(FILT_LEN - 1));
    cnt_d  = (diff && !done) ? cnt_q + 1'b1 : '0;
    filt_d = done ? ~filt_q : filt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
  assign filt_o = filt_q;
endmodule

// File: rtl/quad_paddle_ctrl.sv
// quad_paddle_ctrl: filtered x4 quadrature decoder driving a saturating paddle position
module quad_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W       = PADDLE_POS_W,
  parameter int POS_MIN     = PADDLE_MIN,
  parameter int POS_MAX     = PADDLE_MAX,
  parameter int POS_INIT    = PADDLE_INIT,
  parameter int STEP        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rot_a,
  input  logic             rot_b,
  input  logic             center_req,
  output logic [POS_W-1:0] pos,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             quad_err,
  output logic [7:0]       err_cnt
);
  localparam int PRIME_N = SYNC_STAGES + FILT_LEN + 1;
  localparam int PW      = $clog2(PRIME_N + 1);
  typedef logic [POS_W:0] wpos_t;
  localparam wpos_t P_MIN  = wpos_t'(POS_MIN);
  localparam wpos_t P_MAX  = wpos_t'(POS_MAX);
  localparam wpos_t P_INIT = wpos_t'(POS_INIT);
  localparam wpos_t P_STEP = wpos_t'(STEP);
  logic fa, fb, primed;
  logic [1:0] state, prev_q;
  logic [PW-1:0] prime_q, prime_d;
  quad_ev_t ev;
  wpos_t pos_q, pos_d, up, dn;
  logic [7:0] err_q, err_d;
  logic cw_q, ccw_q, qerr_q;
  pin_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fa (
    .clk(clk), .rst(rst), .pin_i(rot_a), .filt_o(fa)
  );
  pin_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fb (
    .clk(clk), .rst(rst), .pin_i(rot_b), .filt_o(fb)
  );
  always_comb begin
    state   = {fa, fb};
    primed  = prime_q == PW'(PRIME_N);
    prime_d = primed ? prime_q : prime_q + 1'b1;
    ev      = primed ? quad_decode(prev_q, state) : QUAD_NONE;
    up      = (pos_q + P_STEP > P_MAX) ? P_MAX : pos_q + P_STEP;
    dn      = (pos_q < P_MIN + P_STEP) ? P_MIN : pos_q - P_STEP;
    pos_d   = center_req ? P_INIT : ev == QUAD_CW ? up : ev == QUAD_CCW ? dn : pos_q;
    err_d   = (ev == QUAD_ERR && err_q != 8'hff) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q <= '0;
      prev_q  <= '0;
      pos_q   <= P_INIT;
      err_q   <= '0;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
      qerr_q  <= 1'b0;
    end else begin
      prime_q <= prime_d;
      prev_q  <= state;
      pos_q   <= pos_d;
      err_q   <= err_d;
      cw_q    <= ev == QUAD_CW;
      ccw_q   <= ev == QUAD_CCW;
      qerr_q  <= ev == QUAD_ERR;
    end
  end
  assign pos      = pos_q[POS_W-1:0];
  assign step_cw  = cw_q;
  assign step_ccw = ccw_q;
  assign quad_err = qerr_q;
  assign err_cnt  = err_q;
endmodule

// File: tb/tb_quad_paddle_ctrl.sv
// tb_quad_paddle_ctrl: randomized and directed checks of quad_paddle_ctrl against a behavioural model
module tb_quad_paddle_ctrl;
  logic clk = 1'b0, rst = 1'b1, rot_a = 1'b0, rot_b = 1'b0, center_req = 1'b0;
  logic [9:0] pos, pos2;
  logic step_cw, step_ccw, quad_err, step_cw2, step_ccw2, quad_err2;
  logic [7:0] err_cnt, err_cnt2;
  int checks = 0, passed = 0;
  bit [7:0] ha, hb;
  bit mfa, mfb, e_cw, e_ccw, e_err;
  logic [1:0] mprev, lvl;
  int n, merr, mpos[2];
  int obs_cw, obs_ccw, obs_err, obs2_cw, exp_cw, exp_ccw, exp_err;
  always #5 clk = ~clk;
  quad_paddle_ctrl dut (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .center_req(center_req),
    .pos(pos), .step_cw(step_cw), .step_ccw(step_ccw), .quad_err(quad_err), .err_cnt(err_cnt)
  );
  quad_paddle_ctrl #(.POS_MAX(519)) dut2 (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .center_req(center_req),
    .pos(pos2), .step_cw(step_cw2), .step_ccw(step_ccw2), .quad_err(quad_err2), .err_cnt(err_cnt2)
  );
  // Clockwise successor of each {a,b} level: 00->10->11->01->00
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    logic [1:0] t [4];
    t = '{2'b10, 2'b00, 2'b11, 2'b01};
    return t[ab];
  endfunction
  function automatic logic [1:0] ccw_next(input logic [1:0] ab);
    logic [1:0] t [4];
    t = '{2'b01, 2'b11, 2'b00, 2'b10};
    return t[ab];
  endfunction
  task automatic tick(input logic a, input logic b, input logic c);
    logic [1:0] cur;
    logic na, nb;
    int mx;
    rot_a = a; rot_b = b; center_req = c;
    @(posedge clk);
    if (rst) begin
      ha = '0; hb = '0; mfa = 0; mfb = 0; mprev = '0; n = 0; merr = 0;
      mpos[0] = 260; mpos[1] = 260; e_cw = 0; e_ccw = 0; e_err = 0;
    end else begin
      ha = {ha[6:0], a}; hb = {hb[6:0], b};
      na = (ha[5:2] == {4{~mfa}}) ? ~mfa : mfa;
      nb = (hb[5:2] == {4{~mfb}}) ? ~mfb : mfb;
      cur = {mfa, mfb};
      n++;
      e_cw  = (n >= 8) && (cur == cw_next(mprev));
      e_ccw = (n >= 8) && (mprev == cw_next(cur));
      e_err = (n >= 8) && (cur == ~mprev);
      for (int i = 0; i < 2; i++) begin
        mx = i ? 519 : 520;
        if (c) mpos[i] = 260;
        else if (e_cw) mpos[i] = (mpos[i] + 2 > mx) ? mx : mpos[i] + 2;
        else if (e_ccw) mpos[i] = (mpos[i] - 2 < 0) ? 0 : mpos[i] - 2;
      end
      if (e_err && merr < 255) merr++;
      mprev = cur; mfa = na; mfb = nb;
    end
    #1;
    obs_cw += int'(step_cw); obs_ccw += int'(step_ccw); obs_err += int'(quad_err);
    obs2_cw += int'(step_cw2);
    exp_cw += int'(e_cw); exp_ccw += int'(e_ccw); exp_err += int'(e_err);
  endtask
  task automatic hold(input logic [1:0] ab, input int k);
    repeat (k) tick(ab[1], ab[0], 1'b0);
  endtask
  task automatic do_reset(input logic [1:0] ab);
    rst = 1'b1;
    hold(ab, 3);
    rst = 1'b0;
    hold(ab, 10);
    lvl = ab;
  endtask
  task automatic test_reset;
    int c0;
    rst = 1'b1;
    hold(2'b01, 3);
    checks++;
    if ({pos, err_cnt, step_cw, step_ccw, quad_err} !== {10'd260, 8'd0, 3'b000})
      $display("FAIL reset_vals: pos=%0d err=%0d pulses=%b, want 260 0 000", pos, err_cnt, {step_cw, step_ccw, quad_err});
    else passed++;
    c0 = obs_cw + obs_ccw + obs_err;
    rst = 1'b0;
    hold(2'b01, 30);
    checks++;
    if (obs_cw + obs_ccw + obs_err - c0 !== 0 || pos !== 10'd260 || err_cnt !== 8'd0)
      $display("FAIL reset_prime: pulses=%0d pos=%0d err=%0d, want 0 260 0", obs_cw + obs_ccw + obs_err - c0, pos, err_cnt);
    else passed++;
  endtask
  task automatic test_cw;
    int lat;
    do_reset(2'b00);
    for (int s = 0; s < 4; s++) begin
      lvl = cw_next(lvl);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        tick(lvl[1], lvl[0], 1'b0);
        if (step_cw && lat == 0) lat = k;
      end
      checks++;
      if (lat !== 7) $display("FAIL cw_latency[%0d]: got %0d, want 7", s, lat);
      else passed++;
    end
    checks++;
    if (pos !== 10'd268 || pos !== 10'(mpos[0])) $display("FAIL cw_pos: got %0d, want 268", pos);
    else passed++;
  endtask
  task automatic test_glitch;
    int c0, p0;
    c0 = obs_cw + obs_ccw; p0 = mpos[0];
    hold(2'b10, 3);
    hold(2'b00, 20);
    checks++;
    if (obs_cw + obs_ccw - c0 !== 0 || pos !== 10'(p0))
      $display("FAIL glitch3: steps=%0d pos=%0d, want 0 %0d", obs_cw + obs_ccw - c0, pos, p0);
    else passed++;
    c0 = obs_cw;
    hold(2'b10, 4);
    hold(2'b00, 20);
    checks++;
    if (obs_cw - c0 !== 1 || pos !== 10'(mpos[0]))
      $display("FAIL glitch4: cw=%0d pos=%0d, want 1 %0d", obs_cw - c0, pos, mpos[0]);
    else passed++;
  endtask
  task automatic test_clamp;
    bit seen518;
    int c0, c2;
    do_reset(2'b00);
    seen518 = 0; c0 = obs_cw; c2 = obs2_cw;
    for (int s = 0; s < 140; s++) begin
      lvl = cw_next(lvl);
      hold(lvl, 8);
      if (pos2 == 10'd518) seen518 = 1;
    end
    checks++;
    if (!seen518 || pos2 !== 10'd519 || pos !== 10'd520)
      $display("FAIL clamp_top: seen518=%0d pos2=%0d pos=%0d, want 1 519 520", seen518, pos2, pos);
    else passed++;
    checks++;
    if (obs_cw - c0 !== 140 || obs2_cw - c2 !== 140)
      $display("FAIL clamp_pulses: cw=%0d cw2=%0d, want 140 140", obs_cw - c0, obs2_cw - c2);
    else passed++;
    for (int s = 0; s < 270; s++) begin
      lvl = ccw_next(lvl);
      hold(lvl, 8);
    end
    checks++;
    if (pos !== 10'd0 || pos2 !== 10'd0 || mpos[0] !== 0)
      $display("FAIL clamp_bottom: pos=%0d pos2=%0d, want 0 0", pos, pos2);
    else passed++;
  endtask
  task automatic test_err;
    int e0;
    do_reset(2'b00);
    e0 = obs_err;
    hold(2'b11, 12);
    checks++;
    if (obs_err - e0 !== 1 || err_cnt !== 8'd1 || pos !== 10'd260)
      $display("FAIL err_single: pulses=%0d err=%0d pos=%0d, want 1 1 260", obs_err - e0, err_cnt, pos);
    else passed++;
    hold(2'b01, 12);
    checks++;
    if (pos !== 10'd262 || err_cnt !== 8'd1) $display("FAIL err_resume: pos=%0d err=%0d, want 262 1", pos, err_cnt);
    else passed++;
    lvl = 2'b01;
    for (int s = 0; s < 300; s++) begin
      lvl = ~lvl;
      hold(lvl, 8);
    end
    checks++;
    if (err_cnt !== 8'd255 || err_cnt !== 8'(merr)) $display("FAIL err_sat: err=%0d, want 255", err_cnt);
    else passed++;
    checks++;
    if (obs_err !== exp_err || pos !== 10'(mpos[0])) $display("FAIL err_model: errs=%0d pos=%0d, want %0d %0d", obs_err, pos, exp_err, mpos[0]);
    else passed++;
  endtask
  task automatic test_center;
    int c0;
    do_reset(2'b00);
    for (int s = 0; s < 20; s++) begin
      lvl = cw_next(lvl);
      hold(lvl, 8);
    end
    checks++;
    if (pos !== 10'd300) $display("FAIL center_pre: pos=%0d, want 300", pos);
    else passed++;
    lvl = ccw_next(lvl);
    hold(lvl, 6);
    tick(lvl[1], lvl[0], 1'b1);
    checks++;
    if (step_ccw !== 1'b1 || pos !== 10'd260) $display("FAIL center_vs_ccw: ccw=%b pos=%0d, want 1 260", step_ccw, pos);
    else passed++;
    hold(lvl, 10);
    lvl = cw_next(lvl);
    hold(lvl, 3);
    rst = 1'b1;
    hold(lvl, 2);
    rst = 1'b0;
    c0 = obs_cw + obs_ccw + obs_err;
    hold(lvl, 20);
    checks++;
    if (obs_cw + obs_ccw + obs_err - c0 !== 0 || pos !== 10'd260)
      $display("FAIL rst_mid: pulses=%0d pos=%0d, want 0 260", obs_cw + obs_ccw + obs_err - c0, pos);
    else passed++;
  endtask
  task automatic test_random;
    logic [1:0] ab;
    int len, cyc;
    do_reset(2'b00);
    cyc = 0;
    while (cyc < 1500) begin
      ab = 2'($urandom_range(3));
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        tick(ab[1], ab[0], $urandom_range(15) == 0);
        cyc++;
        checks++;
        if (pos !== 10'(mpos[0]) || pos2 !== 10'(mpos[1]))
          $display("FAIL rand_pos@%0d: got %0d/%0d, want %0d/%0d", cyc, pos, pos2, mpos[0], mpos[1]);
        else passed++;
        checks++;
        if ({step_cw, step_ccw, quad_err, err_cnt} !== {e_cw, e_ccw, e_err, 8'(merr)})
          $display("FAIL rand_ev@%0d: got %b %0d, want %b %0d", cyc, {step_cw, step_ccw, quad_err}, err_cnt, {e_cw, e_ccw, e_err}, merr);
        else passed++;
      end
    end
  endtask
  initial begin
    test_reset;
    test_cw;
    test_glitch;
    test_clamp;
    test_err;
    test_center;
    test_random;
    checks++;
    if (obs_cw !== exp_cw || obs_ccw !== exp_ccw || obs_err !== exp_err)
      $display("FAIL pulse_totals: got %0d/%0d/%0d, want %0d/%0d/%0d", obs_cw, obs_ccw, obs_err, exp_cw, exp_ccw, exp_err);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
